pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bundle for the pipeline register: hazard controls and the payload in, stage DEPTH state out.
// The master drives the controls and payload; the slave is the register chain.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12
);
  logic              StallIn;
  logic              FlushIn;
  logic              FlushAllIn;
  logic              ValidIn;
  logic [DATA_W-1:0] DataIn;
  logic [CTRL_W-1:0] CtrlIn;
  logic [DATA_W-1:0] DataOut;
  logic [CTRL_W-1:0] CtrlOut;
  logic              ValidOut;
  logic [2:0]        Occupancy;
  logic [15:0]       BubbleCnt;

  modport master (
    output StallIn, FlushIn, FlushAllIn, ValidIn, DataIn, CtrlIn,
    input  DataOut, CtrlOut, ValidOut, Occupancy, BubbleCnt
  );

  modport slave (
    input  StallIn, FlushIn, FlushAllIn, ValidIn, DataIn, CtrlIn,
    output DataOut, CtrlOut, ValidOut, Occupancy, BubbleCnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Chain of DEPTH pipeline registers with stall, single-stage flush and full flush.
// Keeps a count of valid stages and a saturating count of flush-inserted bubbles.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 12,
  parameter int unsigned DEPTH      = 1,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [2:0]        occ_q, occ_d;
  logic [15:0]       bub_q, bub_d;

  // A bubble either zeroes the payload or leaves the old one in place.
  function automatic logic [DATA_W-1:0] bubble_data(input logic [DATA_W-1:0] d);
    return CLEAR_DATA ? '0 : d;
  endfunction

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    bub_d   = bub_q;
    occ_d   = '0;
    if (bus.FlushAllIn) begin
      valid_d = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        ctrl_d[k] = '0;
        data_d[k] = bubble_data(data_q[k]);
      end
    end else begin
      if (!bus.StallIn) begin
        for (int k = 1; k < int'(DEPTH); k++) begin
          valid_d[k] = valid_q[k-1];
          ctrl_d[k]  = ctrl_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end
      // Flush (with or without stall) and an empty slot both bubble stage 1.
      if (bus.FlushIn || (!bus.StallIn && !bus.ValidIn)) begin
        valid_d[0] = 1'b0;
        ctrl_d[0]  = '0;
        data_d[0]  = bubble_data(data_q[0]);
      end else if (!bus.StallIn) begin
        valid_d[0] = 1'b1;
        ctrl_d[0]  = bus.CtrlIn;
        data_d[0]  = bus.DataIn;
      end
      if (bus.FlushIn && (bub_q != 16'hFFFF)) begin
        bub_d = bub_q + 16'd1;
      end
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_d = occ_d + 3'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      bub_q   <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
      bub_q   <= bub_d;
    end
  end

  assign bus.DataOut   = data_q[DEPTH-1];
  assign bus.CtrlOut   = ctrl_q[DEPTH-1];
  assign bus.ValidOut  = valid_q[DEPTH-1];
  assign bus.Occupancy = occ_q;
  assign bus.BubbleCnt = bub_q;

endmodule
